// File: rtl/fsk_transmitter.sv
// fsk_transmitter: serialises a byte as a binary-FSK square-wave carrier,
// one carrier frequency per bit value, with a valid/ready byte handshake.
module fsk_transmitter #(
    parameter int HALF_PERIOD_1   = 8,
    parameter int HALF_PERIOD_0   = 24,
    parameter int PERIODS_PER_BIT = 4,
    parameter int MSB_FIRST       = 1
) (
    input  logic       clk,
    input  logic       as_reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       fsk_output,
    output logic       tx_busy,
    output logic       frame_done
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0] HP1_M1 = 8'(HALF_PERIOD_1 - 1);
    localparam logic [7:0] HP0_M1 = 8'(HALF_PERIOD_0 - 1);
    localparam logic [7:0] PPB_M1 = 8'(PERIODS_PER_BIT - 1);

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] half_cnt_q, half_cnt_d;
    logic [7:0] per_cnt_q, per_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       fsk_q, fsk_d;
    logic       done_q, done_d;
    logic       cur_bit, half_end, per_end;
    logic [7:0] shreg_next;

    // The bit on air always sits at the outgoing end of the shift register.
    assign cur_bit    = (MSB_FIRST != 0) ? shreg_q[7] : shreg_q[0];
    assign shreg_next = (MSB_FIRST != 0) ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
    assign half_end   = half_cnt_q == (cur_bit ? HP1_M1 : HP0_M1);
    assign per_end    = per_cnt_q == PPB_M1;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        half_cnt_d = half_cnt_q;
        per_cnt_d  = per_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        fsk_d      = fsk_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = SEND;
                    shreg_d    = tx_data;
                    half_cnt_d = 8'd0;
                    per_cnt_d  = 8'd0;
                    bit_cnt_d  = 3'd0;
                    fsk_d      = 1'b1;
                end
            end
            SEND: begin
                if (!half_end) begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end else begin
                    half_cnt_d = 8'd0;
                    fsk_d      = ~fsk_q;
                    // A low half ending closes a carrier period.
                    if (!fsk_q) begin
                        if (!per_end) begin
                            per_cnt_d = per_cnt_q + 8'd1;
                        end else begin
                            per_cnt_d = 8'd0;
                            shreg_d   = shreg_next;
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_d = IDLE;
                                fsk_d   = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge as_reset_n) begin
        if (!as_reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= 8'd0;
            half_cnt_q <= 8'd0;
            per_cnt_q  <= 8'd0;
            bit_cnt_q  <= 3'd0;
            fsk_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            half_cnt_q <= half_cnt_d;
            per_cnt_q  <= per_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            fsk_q      <= fsk_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready   = state_q == IDLE;
    assign tx_busy    = ~tx_ready;
    assign fsk_output = fsk_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_fsk_transmitter.sv
// tb_fsk_transmitter: random and directed frames on MSB-first and LSB-first
// instances, checked against a waveform model built from the bit rules.
module tb_fsk_transmitter;
    localparam int HP1 = 8, HP0 = 24, PPB = 4;

    logic       clk = 1'b0;
    logic       as_reset_n = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       ready_m, fsk_m, busy_m, done_m;
    logic       ready_l, fsk_l, busy_l, done_l;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    fsk_transmitter #(.HALF_PERIOD_1(HP1), .HALF_PERIOD_0(HP0), .PERIODS_PER_BIT(PPB), .MSB_FIRST(1)) u_msb (
        .clk(clk), .as_reset_n(as_reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_m), .fsk_output(fsk_m), .tx_busy(busy_m), .frame_done(done_m));

    fsk_transmitter #(.HALF_PERIOD_1(HP1), .HALF_PERIOD_0(HP0), .PERIODS_PER_BIT(PPB), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .as_reset_n(as_reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(ready_l), .fsk_output(fsk_l), .tx_busy(busy_l), .frame_done(done_l));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Handshake must already be set up for the next rising edge.
    task automatic frame(input logic [7:0] d, input bit junk, input bit chain, input logic [7:0] nd);
        bit em[$];
        bit el[$];
        int bad_m = -1, bad_l = -1, nbusy = 0, ndone = 0, hm, hl;
        for (int k = 0; k < 8; k++) begin
            hm = d[7-k] ? HP1 : HP0;
            hl = d[k] ? HP1 : HP0;
            for (int p = 0; p < PPB; p++) begin
                for (int h = 0; h < 2 * hm; h++) em.push_back(h < hm);
                for (int h = 0; h < 2 * hl; h++) el.push_back(h < hl);
            end
        end
        check("model_len_equal", el.size(), em.size());
        for (int i = 0; i < em.size(); i++) begin
            @(negedge clk);
            if (fsk_m !== em[i] && bad_m < 0) bad_m = i;
            if (fsk_l !== el[i] && bad_l < 0) bad_l = i;
            if (ready_m === 1'b0 && busy_m === 1'b1 && ready_l === 1'b0 && busy_l === 1'b1) nbusy++;
            if (done_m !== 1'b0 || done_l !== 1'b0) ndone++;
            if (junk && i < em.size() - 1) begin
                tx_data  = 8'($urandom);
                tx_valid = 1'($urandom);
            end
            if (i == em.size() - 1) begin
                tx_valid = chain;
                tx_data  = nd;
            end
        end
        check($sformatf("wave_msb_first_bad_idx_%02h", d), bad_m, -1);
        check($sformatf("wave_lsb_first_bad_idx_%02h", d), bad_l, -1);
        check($sformatf("busy_cycles_%02h", d), nbusy, em.size());
        check("done_during_frame", ndone, 0);
        @(negedge clk);
        check("end_ready", {ready_m, ready_l, busy_m, busy_l}, 4'b1100);
        check("end_done", {done_m, done_l}, 2'b11);
        check("end_fsk_low", {fsk_m, fsk_l}, 2'b00);
        if (!chain) begin
            @(negedge clk);
            check("done_one_cycle", {done_m, done_l}, 2'b00);
        end
    endtask

    initial begin
        logic [7:0] d, nd;
        bit ch;
        #3;
        check("rst_ready_busy", {ready_m, ready_l, busy_m, busy_l}, 4'b1100);
        check("rst_fsk_done", {fsk_m, fsk_l, done_m, done_l}, 4'b0000);
        @(negedge clk);
        as_reset_n = 1'b1;
        @(negedge clk);
        tx_data = 8'hA5; tx_valid = 1'b1;
        frame(8'hA5, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        frame(8'h00, 1'b0, 1'b1, 8'hFF);
        frame(8'hFF, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        tx_data = 8'h01; tx_valid = 1'b1;
        frame(8'h01, 1'b1, 1'b0, 8'h00);
        // Abort in bit 3 of 0xA5 (bits 0..2 take 320 cycles).
        @(negedge clk);
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (370) @(negedge clk);
        check("pre_abort_busy", {busy_m, busy_l}, 2'b11);
        #2 as_reset_n = 1'b0;
        #1;
        check("abort_ready_busy", {ready_m, ready_l, busy_m, busy_l}, 4'b1100);
        check("abort_fsk_done", {fsk_m, fsk_l, done_m, done_l}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", {done_m, done_l, fsk_m, fsk_l}, 4'b0000);
        as_reset_n = 1'b1;
        tx_data = 8'h3C; tx_valid = 1'b1;
        frame(8'h3C, 1'b0, 1'b0, 8'h00);
        d = 8'($urandom);
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            nd = 8'($urandom);
            ch = 1'($urandom);
            frame(d, 1'b1, ch, nd);
            d = nd;
            if (!ch) begin
                @(negedge clk);
                tx_data = d; tx_valid = 1'b1;
            end
        end
        frame(d, 1'b1, 1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsk_transmitter.md
FSK_TRANSMITTER -- requirements
Module: fsk_transmitter

Interface
REQ-001 Parameter HALF_PERIOD_1, default 8: clock cycles per carrier half-period for a '1' bit (carrier period 16).
REQ-002 Parameter HALF_PERIOD_0, default 24: clock cycles per carrier half-period for a '0' bit (carrier period 48).
REQ-003 Parameter PERIODS_PER_BIT, default 4: complete carrier periods per transmitted bit.
REQ-004 Parameter MSB_FIRST, default 1: 1 sends tx_data[7] first; 0 sends tx_data[0] first.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 as_reset_n  input  1  asynchronous, active-low reset.
REQ-007 tx_data  input  8  byte to transmit; sampled only on handshake.
REQ-008 tx_valid  input  1  tx_data valid; may stay high across frames.
REQ-009 tx_ready  output  1  block can accept a byte this cycle.
REQ-010 fsk_output  output  1  registered FSK square-wave output; low when idle.
REQ-011 tx_busy  output  1  frame in progress (equals ~tx_ready).
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 Two states, IDLE and SEND, shall be used: IDLE drives tx_ready=1, tx_busy=0, fsk_output=0.
REQ-014 A handshake shall occur on an edge where tx_valid=1 and tx_ready=1; tx_data is captured into an 8-bit shift register, and state becomes SEND.
REQ-015 tx_valid with tx_ready=0 shall be ignored; tx_data changes during SEND shall not affect the frame.
REQ-016 Each carrier period shall be fsk_output high for HALF_PERIOD_b cycles, then low for HALF_PERIOD_b cycles, where b is the current bit.
REQ-017 The first high cycle of bit 0 shall be the cycle immediately after the handshake edge (latency 1); fsk_output is registered.
REQ-018 Each bit shall last exactly PERIODS_PER_BIT*2*HALF_PERIOD_b cycles; the next bit starts with a rising edge with no gap.
REQ-019 Frame length shall be exactly sum over 8 bits of PERIODS_PER_BIT*2*HALF_PERIOD_b cycles; tx_ready is low for exactly that many cycles.
REQ-020 On the edge that ends the final low half-period of bit 7, state shall return to IDLE, tx_ready goes 1, and frame_done is 1 for that one cycle only.
REQ-021 Back-to-back: a handshake in the frame_done cycle shall start the next frame, giving exactly one idle-low cycle between frames.
REQ-022 The half-period counter and period counter shall be 8 bits wide; the bit counter shall be 3 bits wide; none wraps within a frame.
REQ-023 Parameter legality (HALF_PERIOD_x >= 1 and <= 127; 2*HALF_PERIOD_1 < 31; 31 <= 2*HALF_PERIOD_0 < 127; PERIODS_PER_BIT 1..255) shall be ensured by the integrator; the RTL need not check it.
REQ-024 The block shall carry no framing, preamble, or parity; the output is the raw carrier only.

Reset
REQ-025 as_reset_n=0 shall immediately force: state IDLE, fsk_output=0, tx_ready=1, tx_busy=0, frame_done=0, all counters and the shift register 0.
REQ-026 Reset during SEND shall abort the frame with no frame_done; after release the block accepts a new byte at the first clock edge.
REQ-027 After reset deasserts, no handshake shall be taken before the first rising clock edge.

Verification
REQ-028 Send tx_data=0xA5 with MSB_FIRST=1 at default parameters -> output pattern 1,0,1,0,0,1,0,1; each '1' bit is 64 cycles of 8 high / 8 low; each '0' bit is 192 cycles of 24 high / 24 low; tx_ready is low for 1024 cycles; frame_done pulses once.
REQ-029 Send 0x00, then 0xFF with tx_valid held high -> 1536-cycle frame, frame_done, 1 low cycle, 512-cycle frame, frame_done.
REQ-030 Send 0x01 with MSB_FIRST=0 -> first bit uses 8-cycle half-periods, and the remaining 7 bits use 24-cycle half-periods.
REQ-031 Pulse as_reset_n low mid-bit-3 of a frame -> fsk_output=0 and tx_ready=1 asynchronously; no frame_done; the next byte transmits correctly.
REQ-032 Toggle tx_data and tx_valid randomly during SEND -> the transmitted waveform is unchanged, and no extra handshake occurs.
REQ-033 Run a loopback through the team FSK receiver (thresholds 31/127) with random bytes -> the decoded bit stream matches the input, and fsk_input_present deasserts 127 cycles after the final rising edge.
